// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t  - responder FSM states (IDLE -> WAIT -> RESP)
//   MMIO_LED_ADDR - byte address decoded to the LED register when MMIO_EN is defined
//   word_t        - 32-bit data word
//   is_misaligned - true when a byte address is not word aligned
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [31:0] MMIO_LED_ADDR = 32'hFFFF_FFF0;

  typedef logic [31:0] word_t;

  function automatic logic is_misaligned(input word_t a);
    return (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_responder_ram_sp.sv
// ram_sp: single-port word RAM, synchronous write, combinational read.
// Contents are never reset.
// Ports:
//   clk     in  rising-edge clock
//   i_we    in  write enable (commits at the rising edge)
//   i_addr  in  word index, shared by read and write
//   i_wdata in  write data
//   o_rdata out word at i_addr (combinational)
module ram_sp
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  word_t             i_wdata,
  output word_t             o_rdata
);

  word_t r_mem [2**ADDR_W];

  // Storage write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store bus responder between the MIPS core and its
// word-organised data RAM. Each request is held for WAIT_STATES cycles, then
// completed by a one-cycle ready pulse carrying load data and a misalignment
// error flag.
// Optional feature: define MMIO_EN to map byte address 32'hFFFF_FFF0 onto the
// 8-bit led_out register instead of RAM; otherwise led_out is tied to 0.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active-high
//   req        in   request valid, sampled only in IDLE
//   memwrite   in   1 = store, 0 = load (captured with req)
//   addr       in   byte address (captured with req)
//   writedata  in   store data (captured with req)
//   readdata   out  load data, 0 unless ready
//   ready      out  one-cycle completion pulse
//   err        out  misaligned access flag, 0 unless ready
//   led_out    out  memory-mapped LED register
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err,
  output logic [7:0]  led_out
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  word_t       r_addr;
  word_t       r_wdata;
  logic        r_ready;
  logic        r_err;
  word_t       r_rdata;
  logic [7:0]  r_led;

  word_t             w_sel_addr;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_idx;
  logic              w_misal;
  logic              w_is_mmio;
  logic              w_ram_we;
  logic              w_led_we;
  word_t             w_ram_rdata;
  word_t             w_rsp_data;

  // In IDLE the live bus is the access about to be accepted (matters when
  // WAIT_STATES=0 and the response is formed on the accept edge); afterwards
  // the captured copy is used so bus changes cannot disturb the access.
  assign w_sel_addr = (r_state == IDLE) ? addr : r_addr;
  assign w_sel_we   = (r_state == IDLE) ? memwrite : r_we;
  assign w_idx      = w_sel_addr[ADDR_W+1:2];
  assign w_misal    = is_misaligned(w_sel_addr);

`ifdef MMIO_EN
  assign w_is_mmio = (w_sel_addr == MMIO_LED_ADDR);
`else
  assign w_is_mmio = 1'b0;
`endif

  // Upper address bits only feed the MMIO decode.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, w_sel_addr[31:ADDR_W+2]};

  // Stores commit on the edge that ends RESP; errors never write.
  assign w_ram_we = (r_state == RESP) && r_we && !w_misal && !w_is_mmio;
  assign w_led_we = (r_state == RESP) && r_we && !w_misal && w_is_mmio;

  ram_sp #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Response data registered on entry to RESP; RAM and LED cannot change
  // between that edge and the RESP cycle, so this equals an in-RESP read.
  always_comb begin
    w_rsp_data = 32'd0;
    if (w_misal || w_sel_we) begin
      w_rsp_data = 32'd0;
    end else if (w_is_mmio) begin
      w_rsp_data = {24'd0, r_led};
    end else begin
      w_rsp_data = w_ram_rdata;
    end
  end

  // Responder FSM with wait counter, request capture and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_led   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
          if (req) begin
            r_we    <= memwrite;
            r_addr  <= addr;
            r_wdata <= writedata;
            if (WAIT_STATES > 0) begin
              r_state <= WAIT;
              r_cnt   <= WS_LOAD;
            end else begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_err   <= w_misal;
              r_rdata <= w_rsp_data;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_err   <= w_misal;
            r_rdata <= w_rsp_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
          if (w_led_we) begin
            r_led <= r_wdata[7:0];
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
        end
      endcase
    end
  end

  assign readdata = r_rdata;
  assign ready    = r_ready;
  assign err      = r_err;
  assign led_out  = r_led;

endmodule
